uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity modes, shifter states
// and a constant-width helper.
package uart_pkg;

   localparam logic [1:0] PARITY_NONE = 2'd0;
   localparam logic [1:0] PARITY_ODD  = 2'd1;
   localparam logic [1:0] PARITY_EVEN = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; push is refused when full
// and pop is ignored when empty, so occupancy can never overflow or underflow.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        pop_data,
   output logic                    full,
   output logic                    empty,
   output logic [clog2(DEPTH):0]   count
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign pop_data = mem_reg[rd_ptr_reg];
   assign full     = (count_reg == (AW+1)'(DEPTH));
   assign empty    = (count_reg == '0);
   assign count    = count_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from an internal FIFO; frames stream back to back with
// no idle gap while words are queued. Parity and stop count latch per frame.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = 8,
   parameter int DATA_BITS      = 8,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [DATA_BITS-1:0]        tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   input  logic [1:0]                  parity_mode,
   input  logic                        two_stop,
   output logic                        uart_data,
   output logic                        busy,
   output logic [clog2(FIFO_DEPTH):0]  fifo_count
);

   localparam int CW = clog2(2 * CLOCKS_PER_BIT);
   localparam int BW = clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] BIT_LAST   = CW'(CLOCKS_PER_BIT - 1);
   localparam logic [CW-1:0] STOP2_LAST = CW'(2 * CLOCKS_PER_BIT - 1);
   localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);

   tx_state_t            state_reg;
   logic                 uart_data_reg;
   logic [CW-1:0]        clk_cnt_reg;
   logic [BW-1:0]        bit_cnt_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 parity_bit_reg;
   logic                 parity_en_reg;
   logic                 two_stop_reg;

   logic                 fifo_push;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_head;
   logic                 bit_done;
   logic                 stop_done;
   logic                 load_frame;
   logic                 parity_en_next;
   logic                 parity_bit_next;

   assign tx_ready  = !fifo_full;
   assign fifo_push = tx_valid && tx_ready;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (tx_data),
      .pop       (load_frame),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign bit_done   = (clk_cnt_reg == BIT_LAST);
   assign stop_done  = (clk_cnt_reg == (two_stop_reg ? STOP2_LAST : BIT_LAST));
   // A new frame starts either from idle or on the final stop clock.
   assign load_frame = !fifo_empty &&
                       ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && stop_done));

   always_comb begin
      parity_en_next  = 1'b0;
      parity_bit_next = 1'b0;
      case (parity_mode)
         PARITY_ODD: begin
            parity_en_next  = 1'b1;
            parity_bit_next = ~^fifo_head;
         end
         PARITY_EVEN: begin
            parity_en_next  = 1'b1;
            parity_bit_next = ^fifo_head;
         end
         PARITY_NONE: parity_en_next = 1'b0;
         default:     parity_en_next = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg      <= ST_IDLE;
         uart_data_reg  <= 1'b1;
         clk_cnt_reg    <= '0;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         parity_bit_reg <= 1'b0;
         parity_en_reg  <= 1'b0;
         two_stop_reg   <= 1'b0;
      end else if (load_frame) begin
         state_reg      <= ST_START;
         uart_data_reg  <= 1'b0;
         clk_cnt_reg    <= '0;
         shift_reg      <= fifo_head;
         parity_bit_reg <= parity_bit_next;
         parity_en_reg  <= parity_en_next;
         two_stop_reg   <= two_stop;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               uart_data_reg <= 1'b1;
            end
            ST_START: begin
               if (bit_done) begin
                  state_reg     <= ST_DATA;
                  uart_data_reg <= shift_reg[0];
                  clk_cnt_reg   <= '0;
                  bit_cnt_reg   <= '0;
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  clk_cnt_reg <= '0;
                  if (bit_cnt_reg == DATA_LAST) begin
                     if (parity_en_reg) begin
                        state_reg     <= ST_PARITY;
                        uart_data_reg <= parity_bit_reg;
                     end else begin
                        state_reg     <= ST_STOP;
                        uart_data_reg <= 1'b1;
                     end
                  end else begin
                     bit_cnt_reg   <= bit_cnt_reg + BW'(1);
                     shift_reg     <= shift_reg >> 1;
                     uart_data_reg <= shift_reg[1];
                  end
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
            ST_PARITY: begin
               if (bit_done) begin
                  state_reg     <= ST_STOP;
                  uart_data_reg <= 1'b1;
                  clk_cnt_reg   <= '0;
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
            ST_STOP: begin
               if (stop_done) begin
                  state_reg <= ST_IDLE;
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CW'(1);
               end
            end
            default: begin
               state_reg     <= ST_IDLE;
               uart_data_reg <= 1'b1;
            end
         endcase
      end
   end

   assign uart_data = uart_data_reg;
   assign busy      = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8-bit and a 5-bit instance, expected line
// waveforms written out as strings with one character per bit period.
module tb_uart_tx_fifo;

   localparam int CPB = 4;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [7:0] tx_data8;
   logic       tx_valid8;
   logic [4:0] tx_data5;
   logic       tx_valid5;
   logic [1:0] parity_mode;
   logic       two_stop;

   logic       tx_ready8, uart8, busy8;
   logic [2:0] count8;
   logic       tx_ready5, uart5, busy5;
   logic [2:0] count5;

   logic       cur;
   logic       sel_uart, sel_busy, sel_ready;
   logic [2:0] sel_count;

   int total = 0;
   int bad   = 0;
   int k;
   logic rdy;
   logic [7:0] words [6];

   always #5 clock = ~clock;

   uart_tx_fifo #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(4)) dut8 (
      .clock       (clock),
      .reset_n     (reset_n),
      .tx_data     (tx_data8),
      .tx_valid    (tx_valid8),
      .tx_ready    (tx_ready8),
      .parity_mode (parity_mode),
      .two_stop    (two_stop),
      .uart_data   (uart8),
      .busy        (busy8),
      .fifo_count  (count8)
   );

   uart_tx_fifo #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(5), .FIFO_DEPTH(4)) dut5 (
      .clock       (clock),
      .reset_n     (reset_n),
      .tx_data     (tx_data5),
      .tx_valid    (tx_valid5),
      .tx_ready    (tx_ready5),
      .parity_mode (parity_mode),
      .two_stop    (two_stop),
      .uart_data   (uart5),
      .busy        (busy5),
      .fifo_count  (count5)
   );

   assign sel_uart  = cur ? uart5     : uart8;
   assign sel_busy  = cur ? busy5     : busy8;
   assign sel_ready = cur ? tx_ready5 : tx_ready8;
   assign sel_count = cur ? count5    : count8;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [8:0] data);
      int t = 0;
      @(negedge clock);
      if (cur) begin
         tx_data5  = data[4:0];
         tx_valid5 = 1'b1;
      end else begin
         tx_data8  = data[7:0];
         tx_valid8 = 1'b1;
      end
      while (!sel_ready && t < 200) begin
         @(negedge clock);
         t++;
      end
      if (t >= 200) check("push_ready", sel_ready, 1);
      @(posedge clock);
      #1;
      tx_valid5 = 1'b0;
      tx_valid8 = 1'b0;
   endtask

   // Cycle right after acceptance: word queued, line not yet low.
   task automatic pre_start();
      @(negedge clock);
      check("pre_line", sel_uart, 1);
      check("pre_count", sel_count, 1);
   endtask

   task automatic check_frame(input string exp);
      for (int i = 0; i < exp.len() * CPB; i++) begin
         @(negedge clock);
         check($sformatf("line_bit%0d", i / CPB), sel_uart, (exp.getc(i / CPB) == 8'h31) ? 1 : 0);
         if (i == 0) check("busy_mid", sel_busy, 1);
      end
      @(negedge clock);
      check("busy_end", sel_busy, 0);
      check("line_idle", sel_uart, 1);
      $display("frame %s checked", exp);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      reset_n = 1'b0; tx_valid8 = 1'b0; tx_valid5 = 1'b0;
      tx_data8 = '0; tx_data5 = '0; parity_mode = 2'd0; two_stop = 1'b0; cur = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_line", uart8, 1);
      check("rst_busy", busy8, 0);
      check("rst_count", count8, 0);
      check("rst_ready", tx_ready8, 1);
      check("rst_line5", uart5, 1);
      reset_n = 1'b1;

      // 0xA5, no parity, one stop
      push(9'h0A5); pre_start(); check_frame("0101001011");
      // even parity, one stop
      parity_mode = 2'd2;
      push(9'h0A5); pre_start(); check_frame("01010010101");
      // odd parity, two stop
      parity_mode = 2'd1; two_stop = 1'b1;
      push(9'h0A5); pre_start(); check_frame("010100101111");
      parity_mode = 2'd0; two_stop = 1'b0;

      // FIFO fill with back-to-back streaming
      fork
         begin
            k = 0;
            for (int j = 0; j < 600 && k < 6; j++) begin
               @(negedge clock);
               if (j == 5) begin
                  check("full_count", count8, 4);
                  check("full_ready", tx_ready8, 0);
               end
               tx_data8 = words[k]; tx_valid8 = 1'b1; rdy = tx_ready8;
               @(posedge clock);
               if (rdy) k++;
            end
            #1 tx_valid8 = 1'b0;
            check("accepted", k, 6);
         end
         begin
            @(negedge clock);
            pre_start();
            check_frame({"0100000001", "0010000001", "0110000001",
                         "0001000001", "0101000001", "0011000001"});
         end
      join

      // 5-bit instance
      cur = 1'b1;
      parity_mode = 2'd1;
      push(9'h01F); pre_start(); check_frame("01111101");
      parity_mode = 2'd3;
      push(9'h015); pre_start(); check_frame("0101011");
      parity_mode = 2'd0;
      cur = 1'b0;

      // reset mid-frame with a second word queued
      push(9'h0A5); push(9'h03C);
      @(negedge clock);
      check("cnt_pre_rst", count8, 1);
      repeat (11) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("midrst_line", uart8, 1);
      check("midrst_count", count8, 0);
      check("midrst_busy", busy8, 0);
      check("midrst_ready", tx_ready8, 1);
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clock);
         check("line_after_rst", uart8, 1);
      end
      push(9'h0A5); pre_start(); check_frame("0101001011");

      // config change mid-frame applies only to the following frame
      push(9'h0A5); push(9'h03C);
      fork
         check_frame({"0101001011", "000111100011"});
         begin
            repeat (10) @(negedge clock);
            parity_mode = 2'd2;
            two_stop = 1'b1;
         end
      join
      parity_mode = 2'd0; two_stop = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
